// File: rtl/cpu_pkg.sv
// Shared decode types: instruction class, decoded record layout, field positions.
package cpu_pkg;

    // Storage width for the branch target inside the decoded record.
    // Stages with a narrower PC keep the low PC_W bits.
    localparam int unsigned TgtW = 32;

    // Bit positions inside the 32-bit instruction word
    localparam int unsigned CondLo  = 28;
    localparam int unsigned ClsLo   = 26;
    localparam int unsigned IBit    = 25;
    localparam int unsigned OpLo    = 21;
    localparam int unsigned SBit    = 20;
    localparam int unsigned RnLo    = 16;
    localparam int unsigned RdLo    = 12;
    localparam int unsigned RmLo    = 0;
    localparam int unsigned LinkBit = 24;

    // Bit positions inside the 7-bit flags field {I,S,P,U,B,W,L}
    localparam int unsigned FlagI = 6;
    localparam int unsigned FlagS = 5;
    localparam int unsigned FlagL = 0;

    typedef enum logic [1:0] {
        ClsDp  = 2'd0,
        ClsMem = 2'd1,
        ClsBr  = 2'd2,
        ClsUnd = 2'd3
    } instr_class_t;

    typedef struct packed {
        instr_class_t    cls;
        logic [3:0]      cond;
        logic [3:0]      opcode;
        logic [6:0]      flags;
        logic [3:0]      rn;
        logic [3:0]      rd;
        logic [3:0]      rm;
        logic [31:0]     imm32;
        logic [TgtW-1:0] branch_tgt;
        logic            illegal;
    } decoded_instr_t;

    // Rotate right of a 32-bit value.
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface instr_decode_stage_if #(
    parameter int unsigned PC_W = 32
) ();
    // fetch -> decode
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr_in;
    logic [PC_W-1:0] pc_in;
    // decode -> execute
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      cls;
    logic [3:0]      cond;
    logic [3:0]      opcode;
    logic [6:0]      flags;
    logic [3:0]      rn;
    logic [3:0]      rd;
    logic [3:0]      rm;
    logic [31:0]     imm32;
    logic [PC_W-1:0] branch_tgt;
    logic            illegal;

    // Decode stage side
    modport slave (
        input  in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, cls, cond, opcode, flags, rn, rd, rm, imm32,
               branch_tgt, illegal
    );

    // Producer/consumer side (fetch plus execute)
    modport master (
        output in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, cls, cond, opcode, flags, rn, rd, rm, imm32,
               branch_tgt, illegal
    );
endinterface

// File: rtl/instr_field_decode.sv
// Purely combinational split of an ARM-style word plus PC into a decoded record.
module instr_field_decode
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    output decoded_instr_t  dec_o
);

    instr_class_t    cls;
    logic [31:0]     br_off;
    logic [PC_W-1:0] br_tgt;

    // Word offset sign-extended and scaled to bytes; target wraps at 2^PC_W
    assign br_off = {{6{instr_i[23]}}, instr_i[23:0], 2'b00};
    assign br_tgt = pc_i + PC_W'(8) + br_off[PC_W-1:0];

    // Class from bits [27:25]; 10x is a branch only with bit 25 set
    always_comb begin
        unique case (instr_i[ClsLo +: 2])
            2'b00:   cls = ClsDp;
            2'b01:   cls = ClsMem;
            2'b10:   cls = instr_i[IBit] ? ClsBr : ClsUnd;
            default: cls = ClsUnd;
        endcase
    end

    // Populate only the fields the class uses; everything else stays 0
    always_comb begin
        dec_o      = '0;
        dec_o.cls  = cls;
        dec_o.cond = instr_i[CondLo +: 4];
        unique case (cls)
            ClsDp: begin
                dec_o.opcode       = instr_i[OpLo +: 4];
                dec_o.flags[FlagI] = instr_i[IBit];
                dec_o.flags[FlagS] = instr_i[SBit];
                dec_o.rn           = instr_i[RnLo +: 4];
                dec_o.rd           = instr_i[RdLo +: 4];
                if (instr_i[IBit]) begin
                    dec_o.imm32 = ror32({24'd0, instr_i[7:0]}, {instr_i[11:8], 1'b0});
                end else begin
                    dec_o.rm = instr_i[RmLo +: 4];
                end
            end
            ClsMem: begin
                // S position is meaningless for transfers; P,U,B,W,L are [24:20]
                dec_o.flags = {instr_i[IBit], 1'b0, instr_i[24:20]};
                dec_o.rn    = instr_i[RnLo +: 4];
                dec_o.rd    = instr_i[RdLo +: 4];
                if (instr_i[IBit]) begin
                    dec_o.rm = instr_i[RmLo +: 4];
                end else begin
                    dec_o.imm32 = {20'd0, instr_i[11:0]};
                end
            end
            ClsBr: begin
                dec_o.flags[FlagL] = instr_i[LinkBit];
                dec_o.imm32        = br_off;
                dec_o.branch_tgt   = TgtW'(br_tgt);
            end
            ClsUnd: begin
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: field decoder feeding a DEPTH-entry FIFO with per-class retire counters.
module instr_decode_stage
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    instr_decode_stage_if.slave bus,
    output logic [CNT_W-1:0]    cnt_dp,
    output logic [CNT_W-1:0]    cnt_mem,
    output logic [CNT_W-1:0]    cnt_br,
    output logic [CNT_W-1:0]    cnt_und
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    decoded_instr_t dec;
    decoded_instr_t head;
    decoded_instr_t head_out;

    decoded_instr_t  mem_q [DEPTH];
    decoded_instr_t  mem_d [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    logic full;
    logic empty;
    logic push;
    logic pop;

    instr_field_decode #(
        .PC_W (PC_W)
    ) u_field_decode (
        .instr_i (bus.instr_in),
        .pc_i    (bus.pc_in),
        .dec_o   (dec)
    );

    // Extra pointer MSB tells full from empty when the index bits match
    assign full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign empty = wr_ptr_q == rd_ptr_q;
    assign push  = bus.in_valid && !full && !flush;
    assign pop   = !empty && bus.out_ready && !flush;

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;

    // Head payload forced to 0 whenever nothing is valid
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign head_out = empty ? '0 : head;

    assign bus.cls        = head_out.cls;
    assign bus.cond       = head_out.cond;
    assign bus.opcode     = head_out.opcode;
    assign bus.flags      = head_out.flags;
    assign bus.rn         = head_out.rn;
    assign bus.rd         = head_out.rd;
    assign bus.rm         = head_out.rm;
    assign bus.imm32      = head_out.imm32;
    assign bus.branch_tgt = head_out.branch_tgt[PC_W-1:0];
    assign bus.illegal    = head_out.illegal;

    assign cnt_dp  = cnt_q[ClsDp];
    assign cnt_mem = cnt_q[ClsMem];
    assign cnt_br  = cnt_q[ClsBr];
    assign cnt_und = cnt_q[ClsUnd];

    // Next FIFO/counter state; flush overrides both push and pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = dec;
                wr_ptr_d                = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d          = rd_ptr_q + PtrOne;
                cnt_d[head.cls]   = cnt_q[head.cls] + CNT_W'(1);
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '{default: '0};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed decodes plus randomized traffic
// against a queue-based reference model.
module tb_instr_decode_stage;

    localparam int DEPTH = 2;

    typedef logic [93:0] rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [15:0] cnt_dp, cnt_mem, cnt_br, cnt_und;

    int errors = 0;
    int checks = 0;

    rec_t        mq[$];
    logic [15:0] mcnt [4];

    instr_decode_stage_if #(.PC_W(32)) bus ();

    instr_decode_stage #(
        .PC_W  (32),
        .DEPTH (DEPTH),
        .CNT_W (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .bus     (bus),
        .cnt_dp  (cnt_dp),
        .cnt_mem (cnt_mem),
        .cnt_br  (cnt_br),
        .cnt_und (cnt_und)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Reference decode written straight from the instruction-set rules.
    function automatic rec_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        logic [1:0]  c;
        logic [3:0]  op  = 4'd0;
        logic [3:0]  rn  = 4'd0;
        logic [3:0]  rd  = 4'd0;
        logic [3:0]  rm  = 4'd0;
        logic [6:0]  fl  = 7'd0;
        logic [31:0] imm = 32'd0;
        logic [31:0] tgt = 32'd0;
        logic        ill = 1'b0;
        int          off;
        if (w[27:26] == 2'b00) c = 2'd0;
        else if (w[27:26] == 2'b01) c = 2'd1;
        else if (w[27:26] == 2'b10 && w[25]) c = 2'd2;
        else c = 2'd3;
        case (c)
            2'd0: begin
                op = w[24:21];
                fl = {w[25], w[20], 5'b00000};
                rn = w[19:16];
                rd = w[15:12];
                if (w[25]) begin
                    imm = {24'd0, w[7:0]};
                    repeat (2 * int'(w[11:8])) imm = {imm[0], imm[31:1]};
                end else begin
                    rm = w[3:0];
                end
            end
            2'd1: begin
                fl = {w[25], 1'b0, w[24], w[23], w[22], w[21], w[20]};
                rn = w[19:16];
                rd = w[15:12];
                if (w[25]) rm = w[3:0];
                else imm = {20'd0, w[11:0]};
            end
            2'd2: begin
                fl  = {6'd0, w[24]};
                off = int'(w[23:0]);
                if (off >= 8388608) off = off - 16777216;
                imm = 32'(off * 4);
                tgt = pc + 32'd8 + imm;
            end
            default: ill = 1'b1;
        endcase
        return {c, w[31:28], op, fl, rn, rd, rm, imm, tgt, ill};
    endfunction

    function automatic rec_t observe();
        return {bus.cls, bus.cond, bus.opcode, bus.flags, bus.rn, bus.rd, bus.rm,
                bus.imm32, bus.branch_tgt, bus.illegal};
    endfunction

    function automatic logic [63:0] cnt_all();
        return {cnt_dp, cnt_mem, cnt_br, cnt_und};
    endfunction

    function automatic logic [63:0] cnt_model();
        return {mcnt[0], mcnt[1], mcnt[2], mcnt[3]};
    endfunction

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.instr_in  = 32'd0;
        bus.pc_in     = 32'd0;
        flush         = 1'b0;
    endtask

    // Push one word into an empty stage, capture the head a cycle later, then pop it.
    task automatic send_one(input logic [31:0] w, input logic [31:0] pc,
                            output rec_t got, output logic got_valid);
        rec_t r;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.instr_in  = w;
        bus.pc_in     = pc;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        got_valid     = bus.out_valid;
        got           = observe();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        r = ref_decode(w, pc);
        mcnt[r[93:92]] = mcnt[r[93:92]] + 16'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        mcnt = '{default: '0};
        mq.delete();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.out_valid, observe(), cnt_all()} !== '0)
            $display("FAIL reset_state: got valid=%b rec=%h cnt=%h want all 0",
                     bus.out_valid, observe(), cnt_all());
        if ({bus.out_valid, observe(), cnt_all()} !== '0) errors++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_dp();
        rec_t got;
        logic v;
        send_one(32'hE3A01CFF, 32'h40, got, v);
        checks++;
        if (v !== 1'b1) begin
            errors++;
            $display("FAIL dp_latency: got out_valid=%b want 1", v);
        end
        checks++;
        if (got !== {2'd0, 4'hE, 4'hD, 7'b1000000, 4'd0, 4'd1, 4'd0, 32'h0000FF00, 32'd0,
                     1'b0}) begin
            errors++;
            $display("FAIL dp_decode: got %h want cls0 condE opD I rd1 imm FF00", got);
        end
        checks++;
        if (cnt_all() !== cnt_model()) begin
            errors++;
            $display("FAIL dp_count: got %h want %h", cnt_all(), cnt_model());
        end
    endtask

    task automatic test_mem();
        rec_t got;
        logic v;
        send_one(32'hE5912004, 32'h80, got, v);
        checks++;
        if (v !== 1'b1 || got !== {2'd1, 4'hE, 4'h0, 7'b0011001, 4'd1, 4'd2, 4'd0, 32'd4,
                                   32'd0, 1'b0}) begin
            errors++;
            $display("FAIL mem_decode: got v=%b %h want cls1 P U L rn1 rd2 imm4", v, got);
        end
    endtask

    task automatic test_br_und();
        rec_t got;
        logic v;
        send_one(32'hEBFFFFFE, 32'h100, got, v);
        checks++;
        if (v !== 1'b1 || got !== {2'd2, 4'hE, 4'h0, 7'b0000001, 12'd0, 32'hFFFFFFF8,
                                   32'h100, 1'b0}) begin
            errors++;
            $display("FAIL br_decode: got v=%b %h want cls2 L imm FFFFFFF8 tgt 100", v, got);
        end
        send_one(32'hE8000000, 32'h200, got, v);
        checks++;
        if (v !== 1'b1 || got !== {2'd3, 4'hE, 4'h0, 7'd0, 12'd0, 32'd0, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL und_decode: got v=%b %h want cls3 illegal", v, got);
        end
        checks++;
        if (cnt_all() !== cnt_model()) begin
            errors++;
            $display("FAIL class_counts: got %h want %h", cnt_all(), cnt_model());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3];
        logic [31:0] p [3];
        rec_t        got[$];
        rec_t        want;
        logic        accepted;
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            p[i] = $urandom & 32'hFFFF_FFFC;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr_in  = w[0];
        bus.pc_in     = p[0];
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_one_entry_ready: got %b want 1", bus.in_ready);
        end
        bus.instr_in = w[1];
        bus.pc_in    = p[1];
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_ready: got %b want 0", bus.in_ready);
        end
        bus.instr_in = w[2];
        bus.pc_in    = p[2];
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || observe() !== ref_decode(w[0], p[0])) begin
            errors++;
            $display("FAIL bp_hold: got in_ready=%b head=%h want 0 %h", bus.in_ready,
                     observe(), ref_decode(w[0], p[0]));
        end
        bus.out_ready = 1'b1;
        accepted      = 1'b0;
        for (int k = 0; k < 20 && got.size() < 3; k++) begin
            if (bus.out_valid) got.push_back(observe());
            if (accepted) bus.in_valid = 1'b0;
            else if (bus.in_valid && bus.in_ready) accepted = 1'b1;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL bp_drain_count: got %0d entries want 3", got.size());
        end
        for (int i = 0; i < 3; i++) begin
            want = ref_decode(w[i], p[i]);
            mcnt[want[93:92]] = mcnt[want[93:92]] + 16'd1;
            checks++;
            if (i >= got.size() || got[i] !== want) begin
                errors++;
                $display("FAIL bp_order[%0d]: got %h want %h", i,
                         (i < got.size()) ? got[i] : 'x, want);
            end
        end
        checks++;
        if (bus.out_valid !== 1'b0 || cnt_all() !== cnt_model()) begin
            errors++;
            $display("FAIL bp_after: got out_valid=%b cnt=%h want 0 %h", bus.out_valid,
                     cnt_all(), cnt_model());
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr_in  = 32'hE3A01CFF;
        bus.pc_in     = 32'h10;
        @(negedge clk);
        bus.instr_in = 32'hE5912004;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_prefill: got in_ready=%b want 0", bus.in_ready);
        end
        bus.instr_in  = 32'hEBFFFFFE;
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready, observe()} !== {1'b0, 1'b1, 94'd0}) begin
            errors++;
            $display("FAIL flush_empty: got valid=%b ready=%b rec=%h want 0 1 0",
                     bus.out_valid, bus.in_ready, observe());
        end
        checks++;
        if (cnt_all() !== cnt_model()) begin
            errors++;
            $display("FAIL flush_counts: got %h want %h", cnt_all(), cnt_model());
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_capture: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic        iv, ordy, fl, pop, push;
        logic [31:0] w, p;
        rec_t        want;
        mq.delete();
        @(negedge clk);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++;
            if ({bus.out_valid, bus.in_ready} !== {mq.size() > 0, mq.size() < DEPTH}) begin
                errors++;
                $display("FAIL rand_status cyc %0d: got valid=%b ready=%b want %b %b", cyc,
                         bus.out_valid, bus.in_ready, mq.size() > 0, mq.size() < DEPTH);
            end
            want = (mq.size() > 0) ? mq[0] : '0;
            checks++;
            if (observe() !== want) begin
                errors++;
                $display("FAIL rand_head cyc %0d: got %h want %h", cyc, observe(), want);
            end
            checks++;
            if (cnt_all() !== cnt_model()) begin
                errors++;
                $display("FAIL rand_counts cyc %0d: got %h want %h", cyc, cnt_all(),
                         cnt_model());
            end
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            w    = $urandom;
            p    = $urandom & 32'hFFFF_FFFC;
            bus.in_valid  = iv;
            bus.out_ready = ordy;
            bus.instr_in  = w;
            bus.pc_in     = p;
            flush         = fl;
            if (fl) begin
                mq.delete();
            end else begin
                pop  = (mq.size() > 0) && ordy;
                push = iv && (mq.size() < DEPTH);
                if (pop) begin
                    mcnt[mq[0][93:92]] = mcnt[mq[0][93:92]] + 16'd1;
                    void'(mq.pop_front());
                end
                if (push) mq.push_back(ref_decode(w, p));
            end
            @(negedge clk);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr_in  = 32'hE5912004;
        bus.pc_in     = 32'h300;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, observe(), cnt_all()} !== '0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b rec=%h cnt=%h want all 0",
                     bus.out_valid, observe(), cnt_all());
        end
        idle();
        mq.delete();
        mcnt = '{default: '0};
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, cnt_all()} !== {1'b1, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL async_release: got ready=%b valid=%b cnt=%h want 1 0 0",
                     bus.in_ready, bus.out_valid, cnt_all());
        end
    endtask

    initial begin
        test_reset();
        test_dp();
        test_mem();
        test_br_und();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
